// File: rtl/ps2_pkg.sv
// Shared encodings and constants for the PS/2 keyboard receiver and decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [7:0] NO_KEY     = 8'h00;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_key_input_if.sv
// Byte stream from the frame receiver to the make/break decoder.
// Handshake: rx_strobe is a one-cycle valid qualifying rx_byte; the decoder is
// always ready, so there is no ready back-pressure. rx_error pulses on a bad frame
// and is never asserted together with rx_strobe.
interface ps2_key_input_if;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_error;

    modport master (output rx_byte, output rx_strobe, output rx_error);
    modport slave  (input  rx_byte, input  rx_strobe, input  rx_error);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit frame FSM
// with parity/stop checking and a mid-frame idle timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ps2_clk_i,
    input  logic                  ps2_data_i,
    ps2_key_input_if.master       rx,
    output frame_state_e          state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_prev_q;
    frame_state_e  state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt_q;
    logic [TW-1:0] to_cnt_d;
    logic [7:0]    byte_q;
    logic          strobe_q;
    logic          error_q;

    logic fall;
    logic data_bit;
    logic timeout_hit;

    assign fall     = clk_prev_q & ~clk_sync_q[1];
    assign data_bit = data_sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    // Counts clock cycles since the last falling edge while a frame is open.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        if (state_q == ST_IDLE || fall) begin
            to_cnt_d = '0;
        end else begin
            if (to_cnt_q != TO_SAT) to_cnt_d = to_cnt_q + 1'b1;
            timeout_hit = (to_cnt_q >= TO_LAST);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            parity_q  <= 1'b0;
            to_cnt_q  <= '0;
            byte_q    <= 8'h00;
            strobe_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            error_q  <= 1'b0;
            to_cnt_q <= to_cnt_d;
            if (timeout_hit) begin
                state_q <= ST_IDLE;
                error_q <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!data_bit) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_q <= data_bit;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (data_bit && odd_parity_ok(shift_q, parity_q)) begin
                            byte_q   <= shift_q;
                            strobe_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx.rx_byte   = byte_q;
    assign rx.rx_strobe = strobe_q;
    assign rx.rx_error  = error_q;
    assign state_o      = state_q;

endmodule

// File: rtl/ps2_key_input.sv
// PS/2 keyboard input: make/break decoder over the frame receiver, tracking the
// single currently held key.
module ps2_key_input
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         clock,
    input  logic         reset_signal,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [7:0]   user_input,
    output logic         key_valid,
    output logic         frame_error,
    output frame_state_e rx_state_o
);

    ps2_key_input_if rx_if ();

    logic [7:0] user_input_q;
    logic       key_valid_q;
    logic       frame_error_q;
    logic       break_pending_q;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk_i      (clock),
        .rst_i      (reset_signal),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .rx         (rx_if.master),
        .state_o    (rx_state_o)
    );

    // Errors are only re-timed here; they never touch the key or break state.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            user_input_q    <= NO_KEY;
            key_valid_q     <= 1'b0;
            frame_error_q   <= 1'b0;
            break_pending_q <= 1'b0;
        end else begin
            key_valid_q   <= 1'b0;
            frame_error_q <= rx_if.rx_error;
            if (rx_if.rx_strobe) begin
                if (rx_if.rx_byte == NO_KEY || rx_if.rx_byte == EXT_CODE) begin
                    break_pending_q <= break_pending_q;
                end else if (break_pending_q) begin
                    break_pending_q <= 1'b0;
                    if (rx_if.rx_byte == user_input_q) user_input_q <= NO_KEY;
                end else if (rx_if.rx_byte == BREAK_CODE) begin
                    break_pending_q <= 1'b1;
                end else begin
                    user_input_q <= rx_if.rx_byte;
                    key_valid_q  <= 1'b1;
                end
            end
        end
    end

    assign user_input  = user_input_q;
    assign key_valid   = key_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: doc/ps2_key_input.md
PS2_KEY_INPUT -- requirements
Module: ps2_key_input

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning mid-frame idle limit in clock cycles (1 ms at 50 MHz).
REQ-002 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_signal  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clock.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clock.
REQ-006 SHALL have port user_input  output  8  scan code of the currently held key; 0x00 when no key is held.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse when user_input takes a new non-zero value.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse when a parity, stop-bit or timeout error occurs.

Function
REQ-009 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any other use.
REQ-010 SHALL detect a falling edge of the synchronized ps2_clk and sample synchronized ps2_data only on that edge.
REQ-011 SHALL implement frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, taking one falling edge per step.
REQ-012 IDLE: a sampled 0 (start bit) SHALL move the FSM to DATA; a sampled 1 SHALL be ignored.
REQ-013 DATA: SHALL shift in 8 bits LSB first, using a 3-bit bit counter, then move to PARITY.
REQ-014 PARITY: SHALL check for odd parity over the 8 data bits plus the parity bit.
REQ-015 STOP: a sampled 1 with good parity SHALL deliver the byte to the decoder exactly 1 cycle after the stop edge.
REQ-016 STOP: a sampled 0 or bad parity SHALL discard the byte, pulse frame_error, and return the FSM to IDLE.
REQ-017 In DATA, PARITY or STOP, if TIMEOUT_CYCLES cycles pass with no falling edge, the block SHALL pulse frame_error and return to IDLE discarding partial data.
REQ-018 The timeout counter SHALL clear on every falling edge and in IDLE, and SHALL saturate rather than wrap.
REQ-019 Decoder: byte 0xE0 SHALL be ignored and SHALL have no effect on the outputs or on break_pending.
REQ-020 Decoder: byte 0xF0 SHALL set break_pending.
REQ-021 Decoder: the next byte with break_pending set SHALL clear break_pending; if that byte equals user_input, user_input SHALL become 0x00, otherwise user_input is unchanged.
REQ-022 Decoder: any other non-zero byte without break_pending SHALL load user_input and pulse key_valid the same cycle as the load.
REQ-023 A make byte equal to the current user_input (typematic repeat) SHALL pulse key_valid again.
REQ-024 A received byte 0x00 SHALL be ignored.
REQ-025 A frame error SHALL NOT alter break_pending or user_input.
REQ-026 key_valid and frame_error SHALL never both be asserted in the same cycle.

Reset
REQ-027 reset_signal SHALL asynchronously force: FSM=IDLE, user_input=0x00, key_valid=0, frame_error=0, break_pending=0, synchronizers=1, counters=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; reception SHALL resume at the next start bit after release.

Structure
REQ-029 Package ps2_pkg SHALL hold the frame-state encoding and the constants BREAK_CODE=8'hF0, EXT_CODE=8'hE0, NO_KEY=8'h00.
REQ-030 Sub-module ps2_frame_rx SHALL contain the synchronizers, edge detect, frame FSM and timeout, and SHALL output byte, byte_strobe and frame_error.
REQ-031 The top level SHALL contain only the make/break decoder and the output registers.

Verification
REQ-032 Frame 0x1C with parity=0 and stop=1 -> user_input=0x1C, one key_valid pulse, frame_error=0.
REQ-033 Frames 0x1C, then 0xF0, then 0x1C -> user_input returns to 0x00 after the third frame, with a single key_valid pulse.
REQ-034 Frame 0x1C with parity=1 -> frame_error pulses once, user_input unchanged, no key_valid.
REQ-035 Start bit plus 4 data bits, then 50000 idle cycles -> frame_error pulses; a following good 0x32 frame -> user_input=0x32.
REQ-036 Frames 0xE0 then 0x74 -> user_input=0x74; then 0xE0, 0xF0, 0x74 -> user_input=0x00.
REQ-037 reset_signal pulsed after bit 5 of a frame -> outputs at reset values; the next good 0x1C frame is received correctly.
